// File: rtl/alu_control_fsm.sv
// alu_control_fsm: multi-cycle ALU sequencer for the 8-bit CPU.
// Accepts one {opcode, rd, rs} word per valid/ready handshake, then steps
// through DECODE -> EXEC -> (WAIT) -> WB and drives the write enables.
// Optional build macro: WATCHDOG_EN adds a WAIT-state timeout of TIMEOUT cycles.
module alu_control_fsm #(
  parameter int OPCODE_W   = 4,
  parameter int REG_ADDR_W = 2,
  parameter int ALU_SEL_W  = 3,
  parameter int TIMEOUT    = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [OPCODE_W+2*REG_ADDR_W-1:0]   instr,
  input  logic                               instr_valid,
  output logic                               instr_ready,
  output logic [ALU_SEL_W-1:0]               alu_sel,
  output logic                               alu_start,
  input  logic                               alu_done,
  output logic [REG_ADDR_W-1:0]              rs_addr,
  output logic [REG_ADDR_W-1:0]              wr_addr,
  output logic                               reg_we,
  output logic                               flag_we,
  output logic                               busy,
  output logic                               illegal_op,
  output logic                               alu_timeout
);

  localparam int INSTR_W = OPCODE_W + 2 * REG_ADDR_W;

  // Elaboration-time guard on parameter values the decoder relies on.
  if (ALU_SEL_W < 3 || TIMEOUT < 1) begin : g_bad_params
    $error("alu_control_fsm: ALU_SEL_W must be >= 3 and TIMEOUT >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WAIT   = 3'd3,
    S_WB     = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [INSTR_W-1:0]      instr_q, instr_d;
  logic [ALU_SEL_W-1:0]    alu_sel_q, alu_sel_d;
  logic [REG_ADDR_W-1:0]   rs_addr_q, rs_addr_d;
  logic [REG_ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic                    ready_q, ready_d;

  // Fields of the latched instruction; opcode widened so the 0..7 tests
  // work for any OPCODE_W.
  logic [OPCODE_W-1:0]     opcode;
  logic [REG_ADDR_W-1:0]   rd_field, rs_field;
  logic [31:0]             op_ext;
  logic                    op_legal, op_multi, op_cmp;

  assign opcode   = instr_q[INSTR_W-1 -: OPCODE_W];
  assign rd_field = instr_q[2*REG_ADDR_W-1 -: REG_ADDR_W];
  assign rs_field = instr_q[REG_ADDR_W-1:0];
  assign op_ext   = 32'(opcode);
  assign op_legal = (op_ext < 32'd8);
  assign op_multi = (op_ext == 32'd5) || (op_ext == 32'd6);
  assign op_cmp   = (op_ext == 32'd7);

`ifdef WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             timeout_q, timeout_d;
  logic             wd_expired;

  // Counter value CNT is reached during the (CNT+1)-th WAIT cycle.
  assign wd_expired = (wd_cnt_q == CNT_W'(TIMEOUT - 1));

  // Watchdog: count WAIT cycles, zero elsewhere so every WAIT entry starts fresh.
  always_comb begin
    wd_cnt_d  = '0;
    timeout_d = 1'b0;
    if (state_q == S_WAIT) begin
      wd_cnt_d  = wd_cnt_q + CNT_W'(1);
      timeout_d = !alu_done && wd_expired;
    end
  end

  // Watchdog registers; pulse is registered so it never follows alu_done combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign alu_timeout = timeout_q;
`else
  assign alu_timeout = 1'b0;
`endif

  // Next-state and datapath-register logic; holds everything by default.
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    alu_sel_d = alu_sel_q;
    rs_addr_d = rs_addr_q;
    wr_addr_d = wr_addr_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid && ready_q) begin
          instr_d = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (op_legal) begin
          alu_sel_d = ALU_SEL_W'(opcode);
          rs_addr_d = rs_field;
          wr_addr_d = rd_field;
          state_d   = S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: state_d = op_multi ? S_WAIT : S_WB;
      S_WAIT: begin
        if (alu_done) begin
          state_d = S_WB;
        end
`ifdef WATCHDOG_EN
        else if (wd_expired) begin
          state_d = S_IDLE;
        end
`endif
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Ready is registered so it stays low through the reset cycles.
    ready_d = (state_d == S_IDLE);
  end

  // State and datapath registers; reset lands in IDLE with everything cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      instr_q   <= '0;
      alu_sel_q <= '0;
      rs_addr_q <= '0;
      wr_addr_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      alu_sel_q <= alu_sel_d;
      rs_addr_q <= rs_addr_d;
      wr_addr_q <= wr_addr_d;
      ready_q   <= ready_d;
    end
  end

  // Outputs decode only from registered state and the latched instruction.
  assign instr_ready = ready_q;
  assign busy        = (state_q != S_IDLE);
  assign alu_start   = (state_q == S_EXEC);
  assign illegal_op  = (state_q == S_DECODE) && !op_legal;
  assign reg_we      = (state_q == S_WB) && !op_cmp;
  assign flag_we     = (state_q == S_WB) && op_cmp;
  assign alu_sel     = alu_sel_q;
  assign rs_addr     = rs_addr_q;
  assign wr_addr     = wr_addr_q;

endmodule

// File: tb/tb_alu_control_fsm.sv
// Directed bench for alu_control_fsm with default parameters.
// ctrl vector = {instr_ready, busy, alu_start, reg_we, flag_we, illegal_op, alu_timeout}.
module tb_alu_control_fsm;

  logic       clk;
  logic       rst;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] alu_sel;
  logic       alu_start;
  logic       alu_done;
  logic [1:0] rs_addr;
  logic [1:0] wr_addr;
  logic       reg_we;
  logic       flag_we;
  logic       busy;
  logic       illegal_op;
  logic       alu_timeout;

  int checks   = 0;
  int failures = 0;

  logic [6:0] ctrl;
  assign ctrl = {instr_ready, busy, alu_start, reg_we, flag_we, illegal_op, alu_timeout};

  alu_control_fsm dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .alu_sel     (alu_sel),
    .alu_start   (alu_start),
    .alu_done    (alu_done),
    .rs_addr     (rs_addr),
    .wr_addr     (wr_addr),
    .reg_we      (reg_we),
    .flag_we     (flag_we),
    .busy        (busy),
    .illegal_op  (illegal_op),
    .alu_timeout (alu_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag, input logic [6:0] exp);
    chk(tag, 32'(ctrl), 32'(exp));
  endtask

  task automatic chk_regs(input string tag, input logic [2:0] sel, input logic [1:0] rs,
                          input logic [1:0] wr);
    chk({tag, ".alu_sel"}, 32'(alu_sel), 32'(sel));
    chk({tag, ".rs_addr"}, 32'(rs_addr), 32'(rs));
    chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(wr));
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction for one handshake edge; afterwards we are in cycle N+1.
  task automatic issue(input string tag, input logic [7:0] word, input bit keep_valid);
    chk({tag, ".ready_before"}, 32'(instr_ready), 32'd1);
    instr       = word;
    instr_valid = 1'b1;
    tick();
    if (!keep_valid) instr_valid = 1'b0;
    $display("txn %s instr=%b", tag, word);
  endtask

  initial begin
    rst         = 1'b1;
    instr       = 8'h00;
    instr_valid = 1'b0;
    alu_done    = 1'b0;

    // Reset: two edges with rst high, everything quiet.
    tick();
    tick();
    chk_ctrl("reset.ctrl", 7'b0000000);
    chk_regs("reset", 3'd0, 2'd0, 2'd0);
    rst = 1'b0;
    tick();
    chk_ctrl("post_reset.ctrl", 7'b1000000);

    // ADD r1 <- r2: single-cycle latency.
    issue("add", 8'b0000_01_10, 1'b0);
    chk_ctrl("add.n1", 7'b0100000);
    tick();
    chk_ctrl("add.n2", 7'b0110000);
    chk_regs("add.n2", 3'd0, 2'd2, 2'd1);
    tick();
    chk_ctrl("add.n3", 7'b0101000);
    chk_regs("add.n3", 3'd0, 2'd2, 2'd1);
    tick();
    chk_ctrl("add.n4", 7'b1000000);

    // CMP r3, r0: flag write only.
    issue("cmp", 8'b0111_11_00, 1'b0);
    chk_ctrl("cmp.n1", 7'b0100000);
    tick();
    chk_ctrl("cmp.n2", 7'b0110000);
    chk_regs("cmp.n2", 3'd7, 2'd0, 2'd3);
    tick();
    chk_ctrl("cmp.n3", 7'b0100100);
    tick();
    chk_ctrl("cmp.n4", 7'b1000000);

    // MUL r2 <- r1 with instr_valid held high and a different word while busy.
    issue("mul", 8'b0101_10_01, 1'b1);
    instr = 8'b0000_11_11;
    chk_ctrl("mul.n1", 7'b0100000);
    tick();
    chk_ctrl("mul.n2", 7'b0110000);
    chk_regs("mul.n2", 3'd5, 2'd1, 2'd2);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_ctrl($sformatf("mul.wait%0d", i), 7'b0100000);
    end
    alu_done = 1'b1;
    tick();
    chk_ctrl("mul.wb", 7'b0101000);
    chk_regs("mul.wb", 3'd5, 2'd1, 2'd2);
    alu_done    = 1'b0;
    instr_valid = 1'b0;
    tick();
    chk_ctrl("mul.done", 7'b1000000);

    // Illegal opcode 10: pulse only, fields keep last values.
    issue("illegal", 8'b1010_00_00, 1'b0);
    chk_ctrl("illegal.n1", 7'b0100010);
    tick();
    chk_ctrl("illegal.n2", 7'b1000000);
    chk_regs("illegal.n2", 3'd5, 2'd1, 2'd2);

    // Stray alu_done while idle has no effect.
    alu_done = 1'b1;
    tick();
    chk_ctrl("idle_done.ctrl", 7'b1000000);
    alu_done = 1'b0;

    // DIV interrupted by reset while in WAIT; later alu_done discarded.
    issue("div_rst", 8'b0110_01_11, 1'b0);
    tick();
    chk_ctrl("div_rst.n2", 7'b0110000);
    chk_regs("div_rst.n2", 3'd6, 2'd3, 2'd1);
    tick();
    chk_ctrl("div_rst.wait", 7'b0100000);
    rst = 1'b1;
    tick();
    chk_ctrl("div_rst.in_reset", 7'b0000000);
    chk_regs("div_rst.in_reset", 3'd0, 2'd0, 2'd0);
    rst      = 1'b0;
    alu_done = 1'b1;
    tick();
    chk_ctrl("div_rst.after", 7'b1000000);
    alu_done = 1'b0;
    tick();
    chk_ctrl("div_rst.idle", 7'b1000000);

    // DIV with alu_done held low.
    issue("div_hang", 8'b0110_00_01, 1'b0);
    tick();
    chk_ctrl("div_hang.n2", 7'b0110000);
`ifdef WATCHDOG_EN
    for (int i = 0; i < 16; i++) begin
      tick();
      chk_ctrl($sformatf("div_hang.wait%0d", i), 7'b0100000);
    end
    tick();
    chk_ctrl("div_hang.timeout", 7'b1000001);
    tick();
    chk_ctrl("div_hang.idle", 7'b1000000);
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      chk_ctrl($sformatf("div_hang.wait%0d", i), 7'b0100000);
    end
    alu_done = 1'b1;
    tick();
    chk_ctrl("div_hang.wb", 7'b0101000);
    chk_regs("div_hang.wb", 3'd6, 2'd1, 2'd0);
    alu_done = 1'b0;
    tick();
    chk_ctrl("div_hang.idle", 7'b1000000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_control_fsm.md
Name: alu_control_fsm

Overview:
- Parametrised multi-cycle successor to the combinational opcode-to-ALU-select decoder.
- Accepts one instruction word per valid/ready handshake and decodes opcode and register fields.
- Sequences the ALU through DECODE, EXEC, optional WAIT and WB states, and drives the register-file and flag write enables.
- Sits between the instruction fetch path and the ALU/register file of the 8-bit CPU. Multi-cycle multiply and divide stall on an ALU completion handshake.

Parameters:
- OPCODE_W, 4: opcode field width. Opcodes 0-7 are legal; 8 to 2^OPCODE_W-1 are illegal.
- REG_ADDR_W, 2: width of each register-address field (rd, rs).
- ALU_SEL_W, 3: ALU select width. Must be at least 3.
- TIMEOUT, 16: WAIT-state cycle limit. Used only with WATCHDOG_EN.

Ports:
- clk, input, 1: the single clock. All state changes on its rising edge.
- rst, input, 1: reset, synchronous and active-high.
- instr, input, OPCODE_W+2*REG_ADDR_W: instruction word = {opcode, rd, rs}, MSB first. Default width 8.
- instr_valid, input, 1: instr is valid this cycle.
- instr_ready, output, 1: block can accept an instruction.
- alu_sel, output, ALU_SEL_W: ALU operation. 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6 DIV, 7 CMP.
- alu_start, output, 1: one-cycle pulse that launches the ALU operation.
- alu_done, input, 1: multi-cycle ALU result ready. Sampled only in WAIT.
- rs_addr, output, REG_ADDR_W: source register read address.
- wr_addr, output, REG_ADDR_W: destination register (rd).
- reg_we, output, 1: register-file write enable, one cycle.
- flag_we, output, 1: flag-register write enable, one cycle (CMP only).
- busy, output, 1: high in every state except IDLE.
- illegal_op, output, 1: one-cycle pulse on an illegal opcode.
- alu_timeout, output, 1: one-cycle watchdog pulse. Tied 0 when the watchdog is compiled out.

Behaviour:
- States: IDLE, DECODE, EXEC, WAIT, WB. The state register is reset to IDLE.
- Reset: while rst=1, all outputs are 0 and instr_ready=0. The first cycle after rst falls is IDLE with instr_ready=1.
- Reset mid-operation returns to IDLE on that edge. No write enable fires and a pending alu_done is discarded.
- IDLE: instr_ready=1. On instr_valid & instr_ready, latch instr into an internal register and go to DECODE. Otherwise stay in IDLE.
- DECODE (1 cycle), illegal opcode (≥8): illegal_op=1 this cycle, then go to IDLE. No alu_start, reg_we or flag_we.
- DECODE, legal opcode: register alu_sel = opcode[ALU_SEL_W-1:0], rs_addr and wr_addr, then go to EXEC.
- alu_sel, rs_addr and wr_addr hold stable from EXEC through WB. They hold their last value in IDLE and are 0 after reset.
- EXEC (1 cycle): alu_start=1. Opcodes 5 and 6 go to WAIT; all other opcodes go to WB.
- WAIT: stay until alu_done=1, then go to WB on that edge. alu_done seen in any other state is ignored.
- WB (1 cycle): opcodes 0-6 drive reg_we=1; opcode 7 drives flag_we=1 with reg_we=0. Then go to IDLE.
- Single-cycle op latency: handshake at edge N. DECODE in cycle N+1, alu_start in N+2, reg_we or flag_we in N+3, instr_ready=1 again in N+4.
- Multi-cycle op latency: reg_we is asserted in the cycle after the cycle in which alu_done is sampled high.
- Never more than one instruction in flight. instr_valid while busy is ignored and instr is not latched.
- All outputs are registered or decoded from state only. There is no combinational path from any input to any output.

Optional Feature:
- Macro: WATCHDOG_EN.
- Defined: an internal counter clears on entry to WAIT and increments each WAIT cycle. If TIMEOUT WAIT cycles pass with no alu_done, alu_timeout=1 for one cycle and the FSM goes to IDLE with no write. The counter resets with rst.
- Not defined: WAIT waits indefinitely, alu_timeout is constant 0, and no counter logic is synthesised.

Test Plan:
- rst for 2 cycles, then instr=8'b0000_01_10 (ADD) with valid -> alu_sel=0, rs_addr=2, alu_start at N+2, reg_we=1 with wr_addr=1 at N+3, instr_ready=1 at N+4.
- instr=8'b0111_11_00 (CMP) -> alu_sel=7, flag_we=1 at N+3, reg_we never asserted.
- instr=8'b0101_10_01 (MUL), alu_done raised 5 cycles after alu_start -> busy=1 throughout, reg_we=1 with wr_addr=2 exactly one cycle after alu_done, no second alu_start.
- instr=8'b1010_00_00 (illegal) -> illegal_op pulse at N+1, no alu_start/reg_we/flag_we, instr_ready=1 at N+2. Also: instr_valid held high while busy -> no extra instructions are accepted.
- DIV in WAIT, rst asserted for 1 cycle, then alu_done pulsed -> IDLE after rst with all outputs 0, no reg_we, instr_ready=1.
- WATCHDOG_EN defined, TIMEOUT=16, DIV with alu_done held 0 -> alu_timeout pulse after 16 WAIT cycles, then IDLE with no reg_we. Macro undefined -> still in WAIT after 100 cycles, alu_timeout=0.
